bcd_mod_counter: RTL and testbench

Parametrised multi-digit BCD modulo counter for the digital clock datapath. One instance covers a seconds/minutes field (mod 60), an hours field (mod 24 or 12), or any mod-N BCD field up to 4 digits. Adds up/down counting, synchronous preset for time setting, and a carry/borrow pulse so instances cascade by wiring carry_out to the next instance's en.

---
 rtl/bcd_mod_counter.sv | 201 ++++++++++++++++++++
 tb/tb_bcd_mod_counter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: parametrised multi-digit packed-BCD modulo counter.
//
// Counts 0..MODULUS-1 in packed BCD, up or down, with a synchronous preset and a
// zero-latency carry/borrow pulse. Instances cascade by wiring carry_out_o of one
// stage to en_i of the next stage.
//
// Parameters:
//   DIGITS      number of BCD digits (1..4)
//   MODULUS     count modulus (2..10**DIGITS)
//
// Ports:
//   clk_i       system clock, rising edge
//   cr_ni       asynchronous active-low clear
//   en_i        count enable, one step per edge
//   up_i        direction, 1 = up, 0 = down
//   load_i      synchronous preset strobe (wins over en_i)
//   load_val_i  packed BCD preset value, digit 0 in [3:0]
//   bcd_o       current count, packed BCD, digit 0 in [3:0]
//   tc_o        terminal count: MODULUS-1 when counting up, 0 when counting down
//   carry_out_o cascade pulse, en_i & tc_o & ~load_i
//   load_err_o  registered preset-reject flag
//
// Build option:
//   BCD_MOD_COUNTER_LOAD_CHECK_EN  when defined, presets with a non-BCD nibble or a
//   value >= MODULUS are rejected (count holds, load_err_o set). When undefined,
//   load_err_o is tied low and every preset is stored unchecked.

module bcd_mod_counter #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MODULUS = 60
) (
  input  logic                  clk_i,
  input  logic                  cr_ni,
  input  logic                  en_i,
  input  logic                  up_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  tc_o,
  output logic                  carry_out_o,
  output logic                  load_err_o
);

  localparam int unsigned W        = 4 * DIGITS;
  localparam int unsigned ModLimit = 10 ** DIGITS;

  // Elaboration-time parameter check.
  if (DIGITS < 1 || DIGITS > 4 || MODULUS < 2 || MODULUS > ModLimit) begin : gen_param_err
    $error("bcd_mod_counter: illegal parameters DIGITS=%0d MODULUS=%0d", DIGITS, MODULUS);
  end

  // Binary to packed BCD, used for the constant wrap value only.
  function automatic logic [W-1:0] int_to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t           = t / 10;
    end
    return r;
  endfunction

  // Ripple increment: a digit at 9 rolls to 0 and carries, any other pattern adds one.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (d == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple decrement: a digit at 0 rolls to 9 and borrows, any other pattern subtracts one.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (b) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          b           = 1'b1;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          b           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0] MaxBcd = int_to_bcd(MODULUS - 1);

  logic [W-1:0] bcd_q, bcd_d;
  logic [W-1:0] step_val;
  logic         at_max, at_zero;

  assign at_max  = (bcd_q == MaxBcd);
  assign at_zero = (bcd_q == '0);

  // Wrap check overrides the ripple result.
  always_comb begin
    step_val = bcd_q;
    if (up_i) begin
      step_val = at_max ? '0 : bcd_inc(bcd_q);
    end else begin
      step_val = at_zero ? MaxBcd : bcd_dec(bcd_q);
    end
  end

  assign tc_o        = up_i ? at_max : at_zero;
  assign carry_out_o = en_i & tc_o & ~load_i;
  assign bcd_o       = bcd_q;

`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN

  logic load_err_q, load_err_d;
  logic nibbles_ok;
  logic load_ok;

  always_comb begin
    nibbles_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val_i[4*i +: 4] > 4'd9) begin
        nibbles_ok = 1'b0;
      end
    end
  end

  // For valid BCD the plain unsigned compare of packed values orders numerically.
  assign load_ok = nibbles_ok && (load_val_i <= MaxBcd);

  always_comb begin
    bcd_d      = bcd_q;
    load_err_d = load_err_q;
    if (load_i) begin
      if (load_ok) begin
        bcd_d      = load_val_i;
        load_err_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en_i) begin
      bcd_d      = step_val;
      load_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge cr_ni) begin
    if (!cr_ni) begin
      bcd_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      load_err_q <= load_err_d;
    end
  end

  assign load_err_o = load_err_q;

`else

  always_comb begin
    bcd_d = bcd_q;
    if (load_i) begin
      bcd_d = load_val_i;
    end else if (en_i) begin
      bcd_d = step_val;
    end
  end

  always_ff @(posedge clk_i or negedge cr_ni) begin
    if (!cr_ni) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign load_err_o = 1'b0;

`endif

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Testbench for bcd_mod_counter: a mod-60 stage cascaded into a mod-24 stage, checked
// against an integer reference model. Honours BCD_MOD_COUNTER_LOAD_CHECK_EN.

module tb_bcd_mod_counter;

  logic       clk = 1'b0;
  logic       cr_n;
  logic       en, up, load;
  logic [7:0] load_val;
  logic       hr_en_tb, hr_load, casc;
  logic [7:0] hr_load_val;

  logic [7:0] sec_bcd, hr_bcd;
  logic       sec_tc, sec_carry, sec_err;
  logic       hr_tc, hr_carry, hr_err;
  logic       hr_en;

  int checks   = 0;
  int failures = 0;

  // Reference state: plain integers plus error flags.
  int m_sec, m_hr;
  bit m_sec_err, m_hr_err;

  always #5 clk = ~clk;

  assign hr_en = casc ? sec_carry : hr_en_tb;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_sec (
    .clk_i       (clk),
    .cr_ni       (cr_n),
    .en_i        (en),
    .up_i        (up),
    .load_i      (load),
    .load_val_i  (load_val),
    .bcd_o       (sec_bcd),
    .tc_o        (sec_tc),
    .carry_out_o (sec_carry),
    .load_err_o  (sec_err)
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_hr (
    .clk_i       (clk),
    .cr_ni       (cr_n),
    .en_i        (hr_en),
    .up_i        (up),
    .load_i      (hr_load),
    .load_val_i  (hr_load_val),
    .bcd_o       (hr_bcd),
    .tc_o        (hr_tc),
    .carry_out_o (hr_carry),
    .load_err_o  (hr_err)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit legal(input logic [7:0] b, input int modulus);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (from_bcd(b) < modulus);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_upd(inout int v, inout bit err, input int modulus,
                           input bit e, input bit u, input bit l, input logic [7:0] lv);
    if (l) begin
`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
      if (legal(lv, modulus)) begin
        v   = from_bcd(lv);
        err = 1'b0;
      end else begin
        err = 1'b1;
      end
`else
      v = from_bcd(lv);
`endif
    end else if (e) begin
      v   = u ? (v + 1) % modulus : (v + modulus - 1) % modulus;
      err = 1'b0;
    end
  endtask

  task automatic check_state(input string where);
    chk({where, ".sec_bcd"}, sec_bcd, to_bcd(m_sec));
    chk({where, ".hr_bcd"}, hr_bcd, to_bcd(m_hr));
    chk({where, ".sec_err"}, 8'(sec_err), 8'(m_sec_err));
    chk({where, ".hr_err"}, 8'(hr_err), 8'(m_hr_err));
  endtask

  // Checks combinational outputs ahead of the edge, clocks once, checks the new state.
  task automatic cycle(input string where);
    bit s_tc, s_cy, h_en, h_tc, h_cy;
    #1;
    s_tc = up ? (m_sec == 59) : (m_sec == 0);
    s_cy = en && s_tc && !load;
    h_en = casc ? s_cy : hr_en_tb;
    h_tc = up ? (m_hr == 23) : (m_hr == 0);
    h_cy = h_en && h_tc && !hr_load;
    chk({where, ".sec_tc"}, 8'(sec_tc), 8'(s_tc));
    chk({where, ".sec_carry"}, 8'(sec_carry), 8'(s_cy));
    chk({where, ".hr_tc"}, 8'(hr_tc), 8'(h_tc));
    chk({where, ".hr_carry"}, 8'(hr_carry), 8'(h_cy));
    @(posedge clk);
    model_upd(m_sec, m_sec_err, 60, en, up, load, load_val);
    model_upd(m_hr, m_hr_err, 24, h_en, up, hr_load, hr_load_val);
    #1;
    check_state(where);
  endtask

  task automatic idle_inputs();
    en = 1'b0; load = 1'b0; load_val = 8'h00;
    hr_en_tb = 1'b0; hr_load = 1'b0; hr_load_val = 8'h00; casc = 1'b0;
  endtask

  initial begin
    cr_n = 1'b0;
    up   = 1'b1;
    idle_inputs();
    m_sec = 0; m_hr = 0; m_sec_err = 1'b0; m_hr_err = 1'b0;

    // Reset state and combinational flags while held in reset.
    #1;
    check_state("reset");
    chk("reset.sec_tc_up", 8'(sec_tc), 8'h00);
    up = 1'b0;
    #1;
    chk("reset.sec_tc_down", 8'(sec_tc), 8'h01);
    chk("reset.sec_carry", 8'(sec_carry), 8'h00);
    @(posedge clk);
    #1;
    cr_n = 1'b1;
    up   = 1'b1;

    // Full up sequence with wrap, cascading into the hours stage.
    en = 1'b1; casc = 1'b1;
    for (int i = 0; i < 61; i++) cycle("upwrap");

    // Reset mid-count: 0x36 -> 0x37, then clear between edges.
    casc = 1'b0; load = 1'b1; load_val = 8'h36;
    cycle("ld36");
    load = 1'b0;
    cycle("to37");
    chk("count37", sec_bcd, 8'h37);
    #2;
    cr_n = 1'b0;
    #1;
    m_sec = 0; m_hr = 0; m_sec_err = 1'b0; m_hr_err = 1'b0;
    chk("async_clear", sec_bcd, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_state("held_in_reset");
    cr_n = 1'b1;

    // Down wrap on the mod-24 stage.
    en = 1'b0; up = 1'b0;
    hr_load = 1'b1; hr_load_val = 8'h01;
    cycle("hr_ld01");
    hr_load = 1'b0; hr_en_tb = 1'b1;
    for (int i = 0; i < 3; i++) cycle("downwrap");
    chk("downwrap_end", hr_bcd, 8'h22);
    hr_en_tb = 1'b0;

    // Load beats enable at terminal count.
    up = 1'b1; load = 1'b1; load_val = 8'h59;
    cycle("ld59");
    en = 1'b1; load_val = 8'h30;
    cycle("load_vs_en");
    chk("load_vs_en_val", sec_bcd, 8'h30);

    // Cascade: 59/23 wrap together.
    en = 1'b0; load = 1'b1; load_val = 8'h59; hr_load = 1'b1; hr_load_val = 8'h23;
    cycle("ld_casc");
    load = 1'b0; hr_load = 1'b0; casc = 1'b1; en = 1'b1;
    cycle("casc_wrap");
    chk("casc_sec", sec_bcd, 8'h00);
    chk("casc_hr", hr_bcd, 8'h00);
    casc = 1'b0;

    // Hold at 0x17 while toggling direction.
    en = 1'b0; load = 1'b1; load_val = 8'h17;
    cycle("ld17");
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = ~up;
      cycle("hold");
    end
    chk("hold_val", sec_bcd, 8'h17);

`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
    load = 1'b1; load_val = 8'h75;
    cycle("ldchk75");
    chk("ldchk75_err", 8'(sec_err), 8'h01);
    load_val = 8'h4A;
    cycle("ldchk4A");
    chk("ldchk4A_err", 8'(sec_err), 8'h01);
    load_val = 8'h42;
    cycle("ldchk42");
    chk("ldchk42_val", sec_bcd, 8'h42);
    chk("ldchk42_err", 8'(sec_err), 8'h00);
    load = 1'b0;
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en          = ($urandom_range(0, 3) != 0);
      up          = 1'($urandom_range(0, 1));
      load        = ($urandom_range(0, 9) == 0);
      load_val    = to_bcd($urandom_range(0, 59));
      casc        = 1'($urandom_range(0, 1));
      hr_en_tb    = 1'($urandom_range(0, 1));
      hr_load     = ($urandom_range(0, 11) == 0);
      hr_load_val = to_bcd($urandom_range(0, 23));
`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
      if ($urandom_range(0, 3) == 0) load_val = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) hr_load_val = 8'($urandom_range(0, 255));
`endif
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
